// File: rtl/audio_circuit.sv
// One TIA audio channel: frequency divider, mode-dependent 9-bit poly/tone register.
// Define AUDIO_VOLUME_OUT_EN to add the registered 4-bit audio_out volume port.
module audio_circuit #(
    parameter logic [8:0] POLY_INIT = 9'h1FF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] opcode,
`ifdef AUDIO_VOLUME_OUT_EN
    output logic [3:0]  audio_out,
`endif
    output logic [8:0]  shiftReg
);

    logic [3:0] audc;
    logic [4:0] audf;
    logic [3:0] audv;
    logic [3:0] audc_q;
    logic [4:0] div_cnt;
    logic [6:0] sub_cnt;
    logic       armed;
    logic       mode_change;
    logic       tick;
    logic       divided;
    logic [6:0] limit;
    logic       wrap;
    logic       fb4;
    logic       fb5;
    logic       fb9;
    logic [8:0] poly5_next;
    logic [8:0] shift_next;
    logic       out_bit;
    logic       unused_bits;

    assign audc = opcode[3:0];
    assign audf = opcode[8:4];
    assign audv = opcode[12:9];
    assign unused_bits = ^{opcode[19:13], audv};

    // The first edge after reset has no previous AUDC to compare against, so it
    // is never treated as a mode change; the reset mode is simply adopted.
    assign mode_change = armed && (audc != audc_q);
    assign tick        = (div_cnt >= audf);

    always_comb begin
        divided = 1'b1;
        limit   = 7'd0;
        case (audc)
            4'h6, 4'hA:       limit = 7'd30;
            4'hC, 4'hD, 4'hF: limit = 7'd2;
            4'hE:             limit = 7'd92;
            default:          divided = 1'b0;
        endcase
    end

    assign wrap = divided && (sub_cnt == limit);

    // Feedback is forced high when the active segment is all zeros to avoid lockup.
    assign fb4 = (shiftReg[3:0] == 4'd0) ? 1'b1 : (shiftReg[3] ^ shiftReg[2]);
    assign fb5 = (shiftReg[4:0] == 5'd0) ? 1'b1 : (shiftReg[4] ^ shiftReg[2]);
    assign fb9 = (shiftReg == 9'd0)      ? 1'b1 : (shiftReg[8] ^ shiftReg[4]);
    assign poly5_next = {shiftReg[8:5], shiftReg[3:0], fb5};

    always_comb begin
        shift_next = shiftReg;
        out_bit    = shiftReg[0];
        case (audc)
            4'h0, 4'hB: begin
                shift_next = POLY_INIT;
                out_bit    = 1'b1;
            end
            4'h1: begin
                shift_next = {shiftReg[8:4], shiftReg[2:0], fb4};
                out_bit    = shiftReg[3];
            end
            4'h2, 4'h3, 4'h7, 4'h9: begin
                shift_next = poly5_next;
                out_bit    = shiftReg[4];
            end
            4'h4, 4'h5: shift_next = {shiftReg[8:1], ~shiftReg[0]};
            4'h8: begin
                shift_next = {shiftReg[7:0], fb9};
                out_bit    = shiftReg[8];
            end
            4'hF: begin
                shift_next = wrap ? poly5_next : shiftReg;
                out_bit    = shiftReg[4];
            end
            default: shift_next = wrap ? {shiftReg[8:1], ~shiftReg[0]} : shiftReg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg <= POLY_INIT;
            div_cnt  <= 5'd0;
            sub_cnt  <= 7'd0;
            audc_q   <= 4'd0;
            armed    <= 1'b0;
        end else begin
            audc_q <= audc;
            armed  <= 1'b1;
            if (mode_change) begin
                div_cnt <= 5'd0;
                sub_cnt <= 7'd0;
            end else if (tick) begin
                div_cnt  <= 5'd0;
                shiftReg <= shift_next;
                if (divided) begin
                    sub_cnt <= wrap ? 7'd0 : sub_cnt + 7'd1;
                end
            end else begin
                div_cnt <= div_cnt + 5'd1;
            end
        end
    end

`ifdef AUDIO_VOLUME_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_out <= 4'd0;
        end else begin
            audio_out <= out_bit ? audv : 4'd0;
        end
    end
`else
    logic unused_out;
    assign unused_out = out_bit;
`endif

endmodule

// File: tb/tb_audio_circuit.sv
// Directed bench for audio_circuit: poly/tone sequences, divider timing, mode change, reset.
// Volume checks are included when AUDIO_VOLUME_OUT_EN is defined.
module tb_audio_circuit;

    logic        clk;
    logic        rst_n;
    logic [19:0] opcode;
    logic [8:0]  shiftReg;
`ifdef AUDIO_VOLUME_OUT_EN
    logic [3:0]  audio_out;
`endif

    int checks   = 0;
    int failures = 0;

    audio_circuit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
`ifdef AUDIO_VOLUME_OUT_EN
        .audio_out(audio_out),
`endif
        .shiftReg (shiftReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [4:0] f, input logic [3:0] v);
        return {7'd0, v, f, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [19:0] op);
        @(negedge clk);
        rst_n  = 1'b0;
        opcode = op;
        #2;
        check("rst_async", 32'(shiftReg), 32'h1FF);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [8:0] poly9_exp [6] = '{9'h1FE, 9'h1FC, 9'h1F8, 9'h1F0, 9'h1E0, 9'h1C1};
    logic [8:0] poly4_exp [4] = '{9'h1FE, 9'h1FC, 9'h1F8, 9'h1F1};
    logic [8:0] poly5_exp [5] = '{9'h1FE, 9'h1FC, 9'h1F8, 9'h1F1, 9'h1E3};

    initial begin
        rst_n  = 1'b1;
        opcode = 20'd0;

        // poly9 followed by a switch to set mode
        do_reset(mk(4'h8, 5'd0, 4'h0));
        for (int i = 0; i < 6; i++) begin
            step(1);
            check($sformatf("poly9_e%0d", i + 1), 32'(shiftReg), 32'(poly9_exp[i]));
        end
        opcode = mk(4'h0, 5'd0, 4'h0);
        step(1);
        check("set_modechg_e7", 32'(shiftReg), 32'h1C1);
        step(1);
        check("set_e8", 32'(shiftReg), 32'h1FF);
        step(2);
        check("set_e10", 32'(shiftReg), 32'h1FF);

        // poly4
        do_reset(mk(4'h1, 5'd0, 4'h0));
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("poly4_e%0d", i + 1), 32'(shiftReg), 32'(poly4_exp[i]));
            check($sformatf("poly4_hi_e%0d", i + 1), 32'(shiftReg[8:4]), 32'h1F);
        end

        // poly5
        do_reset(mk(4'h2, 5'd0, 4'h0));
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("poly5_e%0d", i + 1), 32'(shiftReg), 32'(poly5_exp[i]));
        end

        // div2 tone with AUDF=3: tick every 4 edges
        do_reset(mk(4'h4, 5'd3, 4'h0));
        step(3);
        check("div2_e3", 32'(shiftReg), 32'h1FF);
        step(1);
        check("div2_e4", 32'(shiftReg), 32'h1FE);
        step(3);
        check("div2_e7", 32'(shiftReg), 32'h1FE);
        step(1);
        check("div2_e8", 32'(shiftReg), 32'h1FF);

        // AUDF=31: tick every 32 edges
        do_reset(mk(4'h4, 5'd31, 4'h0));
        step(31);
        check("audf31_e31", 32'(shiftReg), 32'h1FF);
        step(1);
        check("audf31_e32", 32'(shiftReg), 32'h1FE);

        // lowering AUDF below div_cnt ticks on the next edge
        do_reset(mk(4'h4, 5'd10, 4'h0));
        step(5);
        check("audf_low_pre", 32'(shiftReg), 32'h1FF);
        opcode = mk(4'h4, 5'd2, 4'h0);
        step(1);
        check("audf_low_wrap", 32'(shiftReg), 32'h1FE);
        step(2);
        check("audf_low_e2", 32'(shiftReg), 32'h1FE);
        step(1);
        check("audf_low_e3", 32'(shiftReg), 32'h1FF);

        // div6: toggle on every third tick
        do_reset(mk(4'hC, 5'd0, 4'h0));
        step(2);
        check("div6_e2", 32'(shiftReg), 32'h1FF);
        step(1);
        check("div6_e3", 32'(shiftReg), 32'h1FE);
        step(2);
        check("div6_e5", 32'(shiftReg), 32'h1FE);
        step(1);
        check("div6_e6", 32'(shiftReg), 32'h1FF);

        // asynchronous reset mid-sequence
        do_reset(mk(4'h8, 5'd0, 4'h0));
        step(3);
        check("midrst_pre", 32'(shiftReg), 32'h1F8);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async", 32'(shiftReg), 32'h1FF);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef AUDIO_VOLUME_OUT_EN
        do_reset(mk(4'h0, 5'd0, 4'hA));
        check("vol_rst", 32'(audio_out), 32'h0);
        step(1);
        check("vol_set_e1", 32'(audio_out), 32'hA);
        do_reset(mk(4'h4, 5'd0, 4'hA));
        step(1);
        check("vol_div2_e1", 32'(audio_out), 32'hA);
        step(1);
        check("vol_div2_e2", 32'(audio_out), 32'h0);
        step(1);
        check("vol_div2_e3", 32'(audio_out), 32'hA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
